// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV32I core.
// Walks the shared datapath (one ALU, one memory port, register file)
// through FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK]. All control
// outputs are decoded combinationally from the current state and inputs;
// the only flops are the state register, the memory wait counter, the
// latched trap cause and the retired-instruction counter.
//
// Memory handshake: mem_req is asserted for as long as the sequencer sits
// in FETCH or MEM; a request completes in the cycle where mem_req and
// mem_ready are both high, and the sequencer leaves that state on the next
// edge. mem_ready is ignored in every other state.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 alu_equal,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 pc_write,
    output logic [1:0]           pc_sel,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BRANCH  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // Counter only needs to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    next_cause;
    logic          timeout_hit;
    logic          opcode_legal;
    logic          branch_taken;

    // Decode helpers shared by several states.
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
            default:                           opcode_legal = 1'b0;
        endcase
        branch_taken = ((funct3 == 3'b000) && alu_equal) ||
                       ((funct3 == 3'b001) && !alu_equal);
        timeout_hit  = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST) && !mem_ready;
    end

    // Next-state and control-output decode.
    always_comb begin
        next_state = state;
        next_cause = 2'b00;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        pc_write   = 1'b0;
        pc_sel     = 2'b00;
        retire     = 1'b0;
        trap       = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (!opcode_legal) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end else if ((opcode == OP_BRANCH) && (funct3[2:1] != 2'b00)) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_BRANCH;
                end else begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (opcode == OP_BRANCH) begin
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    pc_sel     = branch_taken ? 2'b01 : 2'b00;
                    next_state = S_FETCH;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WRITEBACK;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
                if (opcode == OP_LOAD) begin
                    wb_sel = 2'b01;
                end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
                    wb_sel = 2'b10;
                end
                if (opcode == OP_JAL) begin
                    pc_sel = 2'b01;
                end else if (opcode == OP_JALR) begin
                    pc_sel = 2'b10;
                end
            end
            S_TRAP:  trap = 1'b1;
            default: next_state = S_IDLE;
        endcase
    end

    // State register, memory wait counter, trap cause and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            trap_cause <= 2'b00;
            instret    <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state != S_TRAP) && (next_state == S_TRAP)) begin
                trap_cause <= next_cause;
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer. The driver steps one clock per call to
// cyc() and pushes the control vector it expects for that cycle; the
// monitor pops on the falling edge and compares against the DUT.
module tb_cpu_sequencer;

    localparam int W  = 18;
    localparam int IW = 4;

    // Expected-vector field masks:
    // [17] mem_req [16] mem_we [15] addr_sel [14] ir_write [13] reg_write
    // [12:11] wb_sel [10] pc_write [9:8] pc_sel [7] retire [6] trap
    // [5:4] trap_cause [3:0] instret
    localparam logic [W-1:0] MREQ   = 18'h20000;
    localparam logic [W-1:0] MWE    = 18'h10000;
    localparam logic [W-1:0] ASEL   = 18'h08000;
    localparam logic [W-1:0] IRW    = 18'h04000;
    localparam logic [W-1:0] RW     = 18'h02000;
    localparam logic [W-1:0] WB_MEM = 18'h00800;
    localparam logic [W-1:0] WB_PC4 = 18'h01000;
    localparam logic [W-1:0] PCW    = 18'h00400;
    localparam logic [W-1:0] PC_IMM = 18'h00100;
    localparam logic [W-1:0] PC_ALU = 18'h00200;
    localparam logic [W-1:0] RET    = 18'h00080;
    localparam logic [W-1:0] TRP    = 18'h00040;
    localparam logic [W-1:0] C_ILL  = 18'h00010;
    localparam logic [W-1:0] C_BR   = 18'h00020;
    localparam logic [W-1:0] C_TO   = 18'h00030;
    localparam logic [W-1:0] NONE   = 18'h00000;

    logic          clk;
    logic          rst;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          alu_equal;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic          addr_sel;
    logic          ir_write;
    logic          reg_write;
    logic [1:0]    wb_sel;
    logic          pc_write;
    logic [1:0]    pc_sel;
    logic          retire;
    logic [IW-1:0] instret;
    logic          trap;
    logic [1:0]    trap_cause;

    logic [W-1:0]  exp_q[$];
    string         name_q[$];
    logic [IW-1:0] exp_instret;
    int            checks;
    int            errors;
    logic [W-1:0]  act;

    cpu_sequencer #(
        .MEM_TIMEOUT(4),
        .INSTRET_W  (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .alu_equal (alu_equal),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_write  (ir_write),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .pc_write  (pc_write),
        .pc_sel    (pc_sel),
        .retire    (retire),
        .instret   (instret),
        .trap      (trap),
        .trap_cause(trap_cause)
    );

    assign act = {mem_req, mem_we, addr_sel, ir_write, reg_write, wb_sel,
                  pc_write, pc_sel, retire, trap, trap_cause, instret};

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        string        n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %05h expected %05h", n, act, e);
            end
        end
    end

    function automatic logic [W-1:0] ex(input logic [W-1:0] c);
        return c | {{(W-IW){1'b0}}, exp_instret};
    endfunction

    // Driver tasks
    task automatic cyc(input string nm, input logic mr, input logic ae, input logic [W-1:0] e);
        mem_ready = mr;
        alu_equal = ae;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        exp_instret = '0;
        cyc({nm, "_rst"}, 1'b1, 1'b0, ex(NONE));
        rst = 1'b0;
        cyc({nm, "_idle"}, 1'b1, 1'b0, ex(NONE));
    endtask

    task automatic fetch(input string nm, input int waits);
        for (int i = 0; i < waits; i++) cyc({nm, "_fetch_wait"}, 1'b0, 1'b0, ex(MREQ));
        cyc({nm, "_fetch"}, 1'b1, 1'b0, ex(MREQ | IRW));
    endtask

    task automatic run_op(input string nm, input logic [6:0] op, input logic [2:0] f3,
                          input logic [W-1:0] wb_pc, input int fw);
        opcode = op;
        funct3 = f3;
        fetch(nm, fw);
        cyc({nm, "_decode"}, 1'b1, 1'b0, ex(NONE));
        cyc({nm, "_execute"}, 1'b1, 1'b0, ex(NONE));
        cyc({nm, "_writeback"}, 1'b1, 1'b0, ex(RW | PCW | RET | wb_pc));
        exp_instret = exp_instret + 1'b1;
    endtask

    task automatic run_branch(input string nm, input logic [2:0] f3, input logic ae, input logic taken);
        opcode = 7'b1100011;
        funct3 = f3;
        fetch(nm, 0);
        cyc({nm, "_decode"}, 1'b1, ae, ex(NONE));
        cyc({nm, "_execute"}, 1'b1, ae, ex(PCW | RET | (taken ? PC_IMM : NONE)));
        exp_instret = exp_instret + 1'b1;
    endtask

    task automatic run_load(input string nm, input int waits);
        opcode = 7'b0000011;
        funct3 = 3'b010;
        fetch(nm, 0);
        cyc({nm, "_decode"}, 1'b1, 1'b0, ex(NONE));
        cyc({nm, "_execute"}, 1'b1, 1'b0, ex(NONE));
        for (int i = 0; i < waits; i++) cyc({nm, "_mem_wait"}, 1'b0, 1'b0, ex(MREQ | ASEL));
        cyc({nm, "_mem"}, 1'b1, 1'b0, ex(MREQ | ASEL));
        cyc({nm, "_writeback"}, 1'b1, 1'b0, ex(RW | WB_MEM | PCW | RET));
        exp_instret = exp_instret + 1'b1;
    endtask

    task automatic run_store(input string nm, input int waits);
        opcode = 7'b0100011;
        funct3 = 3'b010;
        fetch(nm, 0);
        cyc({nm, "_decode"}, 1'b1, 1'b0, ex(NONE));
        cyc({nm, "_execute"}, 1'b1, 1'b0, ex(NONE));
        for (int i = 0; i < waits; i++) cyc({nm, "_mem_wait"}, 1'b0, 1'b0, ex(MREQ | MWE | ASEL));
        cyc({nm, "_mem"}, 1'b1, 1'b0, ex(MREQ | MWE | ASEL | PCW | RET));
        exp_instret = exp_instret + 1'b1;
    endtask

    // Stimulus
    initial begin
        checks      = 0;
        errors      = 0;
        exp_instret = '0;
        rst         = 1'b1;
        opcode      = 7'b0110011;
        funct3      = 3'b000;
        alu_equal   = 1'b0;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");

        run_op("op", 7'b0110011, 3'b000, NONE, 0);
        run_branch("beq_taken", 3'b000, 1'b1, 1'b1);
        run_branch("bne_not_taken", 3'b001, 1'b1, 1'b0);
        run_branch("beq_not_taken", 3'b000, 1'b0, 1'b0);
        run_branch("bne_taken", 3'b001, 1'b0, 1'b1);
        run_load("load_wait3", 3);
        run_store("store", 0);
        run_op("jalr", 7'b1100111, 3'b000, WB_PC4 | PC_ALU, 0);
        run_op("jal", 7'b1101111, 3'b000, WB_PC4 | PC_IMM, 0);
        run_op("lui", 7'b0110111, 3'b000, NONE, 0);
        run_op("auipc", 7'b0010111, 3'b000, NONE, 0);
        run_op("opimm", 7'b0010011, 3'b000, NONE, 0);
        run_op("fetch_ready_on_4th", 7'b0110011, 3'b000, NONE, 3);
        for (int i = 0; i < 4; i++) run_op("wrap", 7'b0010011, 3'b000, NONE, 0);

        // Illegal opcode: trap is sticky and ignores inputs.
        opcode = 7'b1111111;
        fetch("illegal", 0);
        cyc("illegal_decode", 1'b1, 1'b0, ex(NONE));
        for (int i = 0; i < 20; i++) cyc("illegal_trap", 1'(i % 2), 1'(i % 3 == 0), ex(TRP | C_ILL));
        do_reset("after_illegal");

        // Unsupported branch condition.
        opcode = 7'b1100011;
        funct3 = 3'b100;
        fetch("bad_branch", 0);
        cyc("bad_branch_decode", 1'b1, 1'b1, ex(NONE));
        for (int i = 0; i < 3; i++) cyc("bad_branch_trap", 1'b1, 1'b1, ex(TRP | C_BR));
        do_reset("after_bad_branch");

        // Fetch timeout after 4 waiting cycles.
        opcode = 7'b0110011;
        funct3 = 3'b000;
        for (int i = 0; i < 4; i++) cyc("fetch_timeout_wait", 1'b0, 1'b0, ex(MREQ));
        for (int i = 0; i < 3; i++) cyc("fetch_timeout_trap", 1'b1, 1'b0, ex(TRP | C_TO));
        do_reset("after_fetch_timeout");

        // Memory-stage timeout on a store.
        opcode = 7'b0100011;
        funct3 = 3'b010;
        fetch("store_timeout", 0);
        cyc("store_timeout_decode", 1'b1, 1'b0, ex(NONE));
        cyc("store_timeout_execute", 1'b1, 1'b0, ex(NONE));
        for (int i = 0; i < 4; i++) cyc("store_timeout_wait", 1'b0, 1'b0, ex(MREQ | MWE | ASEL));
        cyc("store_timeout_trap", 1'b1, 1'b0, ex(TRP | C_TO));
        do_reset("after_store_timeout");

        // Reset while a fetch request is outstanding, then resume.
        run_op("pre_midreset", 7'b0110011, 3'b000, NONE, 0);
        opcode = 7'b0110011;
        cyc("midreset_fetch_wait", 1'b0, 1'b0, ex(MREQ));
        do_reset("midreset");
        run_op("post_midreset", 7'b0110011, 3'b000, NONE, 0);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Steps the shared datapath through fetch, decode, execute, memory and writeback: a single ALU, a single memory port and the register file.
- Takes opcode/funct3 from the instruction register and alu_equal from the ALU.
- Drives datapath enables and muxes, the memory request handshake, the retired-instruction count and the trap indication.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before trapping; 0 disables the timeout.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction register [6:0]; valid from DECODE onward
- funct3  in  3  instruction register [14:12]
- alu_equal  in  1  ALU operands equal
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  request is a store
- addr_sel  out  1  0 = PC, 1 = ALU result as memory address
- ir_write  out  1  load instruction register from memory read data
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 = ALU, 01 = memory data, 10 = PC+4
- pc_write  out  1  PC update enable
- pc_sel  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result (JALR)
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  INSTRET_W  retired-instruction count
- trap  out  1  sticky; core halted
- trap_cause  out  2  00 none, 01 illegal opcode, 10 unsupported branch funct3, 11 memory timeout

Behaviour:
- State register and counters are the only flops; all control outputs decode combinationally from state, opcode, funct3, alu_equal and mem_ready.
- Async reset: state = IDLE, instret = 0, wait counter = 0, trap = 0, trap_cause = 00. All control outputs are 0 in IDLE.
- IDLE: unconditionally goes to FETCH next cycle.
- FETCH: mem_req=1, mem_we=0, addr_sel=0.
  - With mem_ready: ir_write=1, go to DECODE.
  - Otherwise stay.
- DECODE: one cycle, no enables asserted.
  - Legal opcodes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode: go to TRAP, cause 01.
  - BRANCH with funct3 not 000/001: go to TRAP, cause 10.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - BRANCH: pc_write=1, retire=1, go to FETCH. taken = (funct3==000 & alu_equal) | (funct3==001 & !alu_equal). pc_sel = 01 if taken, else 00.
  - LOAD or STORE: go to MEM.
  - All other opcodes: go to WRITEBACK.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - With mem_ready, LOAD: go to WRITEBACK.
  - With mem_ready, STORE: pc_write=1, pc_sel=00, retire=1, go to FETCH.
- WRITEBACK: reg_write=1, pc_write=1, retire=1, go to FETCH.
  - wb_sel = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_sel = 01 for JAL, 10 for JALR, 00 otherwise.
- TRAP: all control outputs 0, trap=1. Only reset exits TRAP.
- Cycle latencies (zero-wait memory):
  - 4 cycles: ALU, LUI, AUIPC, JAL, JALR.
  - 3 cycles: BRANCH.
  - 4 cycles: STORE.
  - 5 cycles: LOAD.
- Wait counter:
  - Increments each cycle in FETCH/MEM while mem_req & !mem_ready.
  - Clears on any state change.
  - When MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT-1 with mem_ready still low, go to TRAP next cycle with cause 11.
  - A mem_ready arriving in that same cycle wins and no trap is taken.
- instret: +1 on every retire cycle; wraps modulo 2^INSTRET_W.
- Reset mid-operation, including while mem_req is high: all outputs drop to 0 immediately (asynchronous). The FSM restarts from IDLE.

Test Plan:
- Reset then opcode 0110011, mem_ready held 1 -> mem_req high in cycle 1. ir_write in cycle 1, reg_write+pc_write+retire in cycle 4 with wb_sel=00, pc_sel=00. instret=1.
- BEQ (1100011, funct3 000) with alu_equal=1 -> EXECUTE asserts pc_write with pc_sel=01, retire=1. BNE with alu_equal=1 -> pc_sel=00.
- LOAD with mem_ready low 3 cycles in MEM -> mem_req, addr_sel=1, mem_we=0 held for 4 cycles. WRITEBACK follows with wb_sel=01. STORE -> mem_we=1, no reg_write.
- JALR -> WRITEBACK asserts wb_sel=10, pc_sel=10. JAL -> wb_sel=10, pc_sel=01.
- Opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=01, outputs held 0 for 20 cycles. rst pulse -> IDLE, trap=0, instret=0.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> trap=1, trap_cause=11 after 4 waiting cycles. Variant with mem_ready on the 4th waiting cycle -> no trap, DECODE follows.
